// File: rtl/cordic_angle_prep.sv
// cordic_angle_prep: folds full-circle phase words into [-pi/2, +pi/2] with a negate flag
// and queues them in a small FIFO ahead of the cordic rotator.
module cordic_angle_prep #(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [17:0]      in_phase,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [17:0]      out_angle,
    output logic             out_negate,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PTR_W:0]   level
);
    localparam logic signed [17:0] HALF_PI = 18'sh10000;
    localparam logic        [17:0] PI      = 18'h20000;
    localparam logic [PTR_W:0]     FULL    = (PTR_W+1)'(DEPTH);

    logic signed [17:0] w_phase_s;
    logic               w_fold;
    logic        [17:0] w_angle;
    logic               w_push;
    logic               w_pop;

    logic [17:0]      r_angle  [DEPTH];
    logic             r_negate [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_level;

    // Outside the half-circle around zero, rotate by pi and let the consumer negate.
    assign w_phase_s = signed'(in_phase);
    assign w_fold    = (w_phase_s > HALF_PI) || (w_phase_s < -HALF_PI);
    assign w_angle   = w_fold ? (in_phase - PI) : in_phase;

    assign in_ready   = (r_level != FULL);
    assign out_valid  = (r_level != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;

    assign out_angle  = r_angle[r_rptr];
    assign out_negate = r_negate[r_rptr];
    assign out_tag    = r_tag[r_rptr];
    assign level      = r_level;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_angle[i]  <= '0;
                r_negate[i] <= 1'b0;
                r_tag[i]    <= '0;
            end
        end else if (w_push) begin
            r_angle[r_wptr]  <= w_angle;
            r_negate[r_wptr] <= w_fold;
            r_tag[r_wptr]    <= in_tag;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Directed bench for cordic_angle_prep: reduction boundaries, FIFO fill/drain, wrap, reset.
module tb_cordic_angle_prep;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [17:0] in_phase;
    logic [3:0]  in_tag;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] out_angle;
    logic        out_negate;
    logic [3:0]  out_tag;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;

    int n_checks = 0;
    int n_errors = 0;

    cordic_angle_prep #(.DEPTH(4), .TAG_W(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_phase(in_phase), .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
        .out_angle(out_angle), .out_negate(out_negate), .out_tag(out_tag),
        .out_valid(out_valid), .out_ready(out_ready), .level(level)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] ref_angle(input logic [17:0] ph);
        int a;
        a = (ph >= 18'h20000) ? int'(ph) - 262144 : int'(ph);
        if (a > 65536 || a < -65536) return 18'((a + 131072) & 32'h3FFFF);
        return ph;
    endfunction

    function automatic logic ref_neg(input logic [17:0] ph);
        int a;
        a = (ph >= 18'h20000) ? int'(ph) - 262144 : int'(ph);
        return (a > 65536 || a < -65536);
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_phase = '0; in_tag = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL reset_level got %0d want 0", level); end
        n_checks++; if (out_angle !== 18'h0 || out_negate !== 1'b0 || out_tag !== 4'h0) begin
            n_errors++; $display("FAIL reset_head got %h/%b/%h want 0/0/0", out_angle, out_negate, out_tag);
        end
    endtask

    task automatic test_reduction();
        logic [17:0] ph [6];
        logic [17:0] ea [6];
        logic        en [6];
        int p, k;
        ph = '{18'h00000, 18'h10000, 18'h10001, 18'h20000, 18'h30000, 18'h3FFFF};
        ea = '{18'h00000, 18'h10000, 18'h30001, 18'h00000, 18'h30000, 18'h3FFFF};
        en = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        p = 0; k = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 6; c++) begin
            if (out_valid) begin
                n_checks++;
                if (k < 6 && (out_angle !== ea[k] || out_negate !== en[k] || out_tag !== 4'(k))) begin
                    n_errors++;
                    $display("FAIL reduce_pop%0d got %h/%b/%0d want %h/%b/%0d", k, out_angle, out_negate, out_tag, ea[k], en[k], k);
                end
                k++;
            end
            if (p < 6 && in_ready) begin
                in_valid = 1'b1; in_phase = ph[p]; in_tag = 4'(p); p++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (k != 6) begin n_errors++; $display("FAIL reduce_count got %0d want 6", k); end
        tick();
        n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL reduce_drained got %0d want 0", level); end
    endtask

    task automatic test_single_push();
        out_ready = 1'b0;
        in_valid = 1'b1; in_phase = 18'h08000; in_tag = 4'h7;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_no_passthru got %0b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || level !== 3'd1) begin
            n_errors++; $display("FAIL single_valid got %0b/%0d want 1/1", out_valid, level);
        end
        n_checks++; if (out_angle !== 18'h08000 || out_negate !== 1'b0 || out_tag !== 4'h7) begin
            n_errors++; $display("FAIL single_head got %h/%b/%h want 08000/0/7", out_angle, out_negate, out_tag);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_pop got %0d/%0b want 0/0", level, out_valid);
        end
    endtask

    task automatic test_fill();
        logic [17:0] fp [5];
        fp = '{18'h01000, 18'h02000, 18'h03000, 18'h04000, 18'h05000};
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_phase = fp[c]; in_tag = 4'(c + 1);
            tick();
        end
        in_phase = fp[4]; in_tag = 4'd5;
        n_checks++; if (in_ready !== 1'b0 || level !== 3'd4) begin
            n_errors++; $display("FAIL fill_full got ready=%0b level=%0d want 0/4", in_ready, level);
        end
        tick();
        n_checks++; if (level !== 3'd4 || out_tag !== 4'd1) begin
            n_errors++; $display("FAIL fill_blocked got level=%0d head=%0d want 4/1", level, out_tag);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd3 || in_ready !== 1'b1 || out_tag !== 4'd2) begin
            n_errors++; $display("FAIL fill_pop got level=%0d ready=%0b head=%0d want 3/1/2", level, in_ready, out_tag);
        end
        tick();
        in_valid = 1'b0;
        n_checks++; if (level !== 3'd4) begin n_errors++; $display("FAIL fill_refill got %0d want 4", level); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_tag !== 4'(i + 2) || out_angle !== fp[i + 1]) begin
                n_errors++;
                $display("FAIL fill_drain%0d got %0b/%0d/%h want 1/%0d/%h", i, out_valid, out_tag, out_angle, i + 2, fp[i + 1]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL fill_empty got %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ph;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_phase = 18'(i * 32'h5000); in_tag = 4'(i);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            ph = 18'(k * 32'h5000);
            n_checks++;
            if (out_tag !== 4'(k) || out_angle !== ref_angle(ph) || out_negate !== ref_neg(ph)) begin
                n_errors++;
                $display("FAIL b2b_head%0d got %0d/%h/%b want %0d/%h/%b", k, out_tag, out_angle, out_negate, k, ref_angle(ph), ref_neg(ph));
            end
            in_valid = 1'b1; in_phase = 18'((k + 2) * 32'h5000); in_tag = 4'(k + 2); out_ready = 1'b1;
            tick();
            n_checks++; if (level !== 3'd2) begin n_errors++; $display("FAIL b2b_level%0d got %0d want 2", k, level); end
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            ph = 18'(k * 32'h5000);
            n_checks++;
            if (out_tag !== 4'(k) || out_angle !== ref_angle(ph) || out_negate !== ref_neg(ph)) begin
                n_errors++;
                $display("FAIL b2b_tail%0d got %0d/%h/%b want %0d/%h/%b", k, out_tag, out_angle, out_negate, k, ref_angle(ph), ref_neg(ph));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_pop_empty();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin
                n_errors++; $display("FAIL empty_pop%0d got %0b/%0d want 0/0", i, out_valid, level);
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_phase = 18'h2ABCD; in_tag = 4'h9;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_angle !== 18'h0ABCD || out_negate !== 1'b1 || out_tag !== 4'h9) begin
            n_errors++; $display("FAIL empty_then_push got %0b/%h/%b/%h want 1/0abcd/1/9", out_valid, out_angle, out_negate, out_tag);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_phase = 18'h01234 + 18'(i); in_tag = 4'(i + 3);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (level !== 3'd3) begin n_errors++; $display("FAIL arst_pre got %0d want 3", level); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1 || out_angle !== 18'h0) begin
            n_errors++; $display("FAIL arst_async got v=%0b l=%0d r=%0b a=%h want 0/0/1/0", out_valid, level, in_ready, out_angle);
        end
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b1; in_phase = 18'h30000; in_tag = 4'hC;
        tick();
        in_valid = 1'b0;
        n_checks++; if (level !== 3'd1 || out_angle !== 18'h30000 || out_negate !== 1'b0 || out_tag !== 4'hC) begin
            n_errors++; $display("FAIL arst_after got l=%0d %h/%b/%h want 1 30000/0/c", level, out_angle, out_negate, out_tag);
        end
    endtask

    initial begin
        test_reset();
        test_reduction();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_pop_empty();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
